// File: rtl/window_integ_pkg.sv
// window_integ_pkg: shared widths and state encoding for window_integrator.
// Contents: DATA_W/DLY_W/LEN_W defaults, derived SUM_W and CNT_W, state_t enum.
package window_integ_pkg;
  localparam int DATA_W = 13;
  localparam int DLY_W = 8;
  localparam int LEN_W = 6;
  localparam int SUM_W = DATA_W + LEN_W;
  localparam int CNT_W = DLY_W > LEN_W ? DLY_W : LEN_W;
  typedef enum logic [1:0] {IDLE, WAIT, ACC, DONE} state_t;
endpackage

// File: rtl/window_counter.sv
// window_counter: loadable down-counter with terminal-count flag.
// Ports: clk, rst (sync, active-high), load/load_val (load wins over dec),
//        dec (count down, stops at 0), last (count is 1, i.e. final cycle of the phase).
module window_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign last = cnt_q == W'(1);
endmodule

// File: rtl/window_integrator.sv
// window_integrator: triggered windowed accumulator over delayed signed samples.
// Ports: clk, rst (sync, active-high), din (signed sample), trig (start pulse),
//        delay/len (latched at accepted trig), sum_out (signed full-precision sum,
//        held), valid (one-cycle strobe), busy, overrun (sticky dropped-trig flag).
// Build option: define WINDOW_INTEG_RETRIG_EN to let trig restart a running window
// (overrun then stays 0).
module window_integrator
  import window_integ_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              trig,
  input  logic [DLY_W-1:0]  delay,
  input  logic [LEN_W-1:0]  len,
  output logic [SUM_W-1:0]  sum_out,
  output logic              valid,
  output logic              busy,
  output logic              overrun
);
  state_t state_q, state_d;
  logic [LEN_W-1:0] n_q, n_d;
  logic [SUM_W-1:0] acc_q, acc_d, sum_q, sum_d;
  logic valid_q, valid_d, ovr_q, ovr_d;
  logic start, cnt_load, cnt_last;
  logic [CNT_W-1:0] cnt_val;
`ifdef WINDOW_INTEG_RETRIG_EN
  assign start = trig;
  assign ovr_d = 1'b0;
`else
  assign start = trig && state_q == IDLE;
  assign ovr_d = ovr_q || (trig && state_q != IDLE);
`endif
  // The counter holds the delay during WAIT and the remaining length during ACC.
  window_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (state_q == WAIT || state_q == ACC),
    .last     (cnt_last)
  );
  // A start overrides the window bookkeeping but not the DONE publish, so a
  // retrigger in DONE still delivers the completing result.
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    acc_d = acc_q;
    sum_d = sum_q;
    valid_d = 1'b0;
    cnt_load = 1'b0;
    cnt_val = CNT_W'(n_q);
    if (state_q == DONE) begin
      sum_d = acc_q;
      valid_d = 1'b1;
      state_d = IDLE;
    end
    if (state_q == ACC) acc_d = acc_q + {{LEN_W{din[DATA_W-1]}}, din};
    if (state_q == WAIT && cnt_last) begin
      state_d = n_q != '0 ? ACC : DONE;
      cnt_load = 1'b1;
    end
    if (state_q == ACC && cnt_last) state_d = DONE;
    if (start) begin
      n_d = len;
      acc_d = '0;
      cnt_load = 1'b1;
      cnt_val = delay != '0 ? CNT_W'(delay) : CNT_W'(len);
      state_d = delay != '0 ? WAIT : len != '0 ? ACC : DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      acc_q <= '0;
      sum_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      acc_q <= acc_d;
      sum_q <= sum_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
    end
  end
  assign sum_out = sum_q;
  assign valid = valid_q;
  // valid is raised as the state returns to IDLE; busy covers that cycle too.
  assign busy = state_q != IDLE || valid_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_window_integrator.sv
// tb_window_integrator: randomized + directed scoreboard bench for window_integrator.
module tb_window_integrator;
  logic clk, rst, trig, valid, busy, overrun;
  logic [12:0] din;
  logic [7:0] delay;
  logic [5:0] len;
  logic [18:0] sum_out;

  window_integrator dut (
    .clk(clk), .rst(rst), .din(din), .trig(trig), .delay(delay), .len(len),
    .sum_out(sum_out), .valid(valid), .busy(busy), .overrun(overrun)
  );

  typedef struct { int ev; int lo; int hi; } exp_t;
  exp_t q[$];
  int din_at[int];
  int cyc = 0, checks = 0, errors = 0;
  int win_lo = 0, win_hi = -1, mode = 0, ramp_t0 = 0, const_v = 0;
  int last_vcyc = -1, vcount = 0;
  longint last_sum = 0;
  bit ovr_exp = 0, mon_en = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, got, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs and update the reference model for the edge they meet.
  task automatic step(input bit t, input int d, input int n);
    int e;
    bit take;
    logic signed [12:0] v;
    @(negedge clk);
    e = cyc + 1;
    take = t;
    trig = t;
    delay = d[7:0];
    len = n[5:0];
    if (t && e <= win_hi) begin
`ifdef WINDOW_INTEG_RETRIG_EN
      if (e < win_hi) void'(q.pop_back());
`else
      take = 0;
      ovr_exp = 1;
`endif
    end
    if (take) begin
      q.push_back('{e + d + n + 1, e + d + 1, e + d + n});
      win_lo = e;
      win_hi = e + d + n + 1;
      if (mode == 1) ramp_t0 = e;
    end
    v = mode == 1 ? 13'(e - ramp_t0) : mode == 2 ? 13'(const_v) : 13'($urandom);
    din = v;
    din_at[e] = int'(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    trig = 0;
    q.delete();
    win_hi = -1;
    ovr_exp = 0;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("busy", longint'(busy), longint'(cyc >= win_lo && cyc <= win_hi));
        chk("overrun", longint'(overrun), longint'(ovr_exp));
        while (q.size() != 0 && q[0].ev < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_valid: got none expected valid at edge %0d", q[0].ev);
          void'(q.pop_front());
        end
        if (valid) begin
          vcount++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got valid at edge %0d expected none", cyc);
          end else begin
            exp_t x;
            longint s;
            x = q.pop_front();
            s = 0;
            for (int k = x.lo; k <= x.hi; k++) s += din_at[k];
            last_sum = longint'($signed(sum_out));
            last_vcyc = cyc;
            chk("valid_edge", cyc, x.ev);
            chk("sum", last_sum, s);
          end
        end
      end
    end
  end

  initial begin
    int t0, t1, vc;
    rst = 1; trig = 0; din = 0; delay = 0; len = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    mon_en = 1;
    repeat (10) step(0, 0, 0);
    chk("rst_sum", longint'(sum_out), 0);
    chk("rst_valid", longint'(valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_overrun", longint'(overrun), 0);

    mode = 1;
    step(1, 3, 4);
    t0 = win_lo;
    repeat (12) step(0, 0, 0);
    chk("ramp_sum", last_sum, 22);
    chk("ramp_edge", last_vcyc, t0 + 8);

    mode = 2;
    const_v = -4096;
    step(1, 0, 63);
    t0 = win_lo;
    repeat (70) step(0, 0, 0);
    chk("neg_full_sum", last_sum, -258048);
    chk("neg_full_edge", last_vcyc, t0 + 64);

    mode = 0;
    step(1, 0, 0);
    t0 = win_lo;
    repeat (4) step(0, 0, 0);
    chk("zero_len_sum", last_sum, 0);
    chk("zero_len_edge", last_vcyc, t0 + 1);

    vc = vcount;
    step(1, 5, 5);
    t0 = win_lo;
    step(0, 0, 0);
    step(1, 5, 5);
    t1 = t0 + 2;
    repeat (20) step(0, 0, 0);
    chk("overlap_count", vcount - vc, 1);
`ifdef WINDOW_INTEG_RETRIG_EN
    chk("retrig_edge", last_vcyc, t1 + 11);
    chk("retrig_ovr", longint'(overrun), 0);
`else
    chk("drop_edge", last_vcyc, t0 + 11);
    chk("drop_ovr", longint'(overrun), 1);
`endif
    do_reset();
    chk("ovr_cleared", longint'(overrun), 0);

    vc = vcount;
    step(1, 0, 20);
    repeat (5) step(0, 0, 0);
    do_reset();
    step(1, 2, 6);
    t0 = win_lo;
    repeat (12) step(0, 0, 0);
    chk("post_rst_count", vcount - vc, 1);
    chk("post_rst_edge", last_vcyc, t0 + 9);

    repeat (600) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      step($urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(0, 12)),
           $urandom_range(0, 4) == 0 ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 63)));
    end
    for (int i = 0; i < 400 && q.size() != 0; i++) step(0, 0, 0);
    step(0, 0, 0);
    chk("drain_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/window_integrator.md
# window_integrator

Triggered windowed accumulator that sits directly downstream of the per-channel 13-bit variable delay line. It consumes the delayed signed samples, waits a programmable number of cycles after a trigger, sums a programmable number of consecutive samples, and publishes the full-precision sum with a one-cycle valid strobe. The feedback arithmetic downstream reads this sum.

## Interface
- DATA_W, 13: sample width, signed
- DLY_W, 8: width of trigger-to-window delay
- LEN_W, 6: width of window length; maximum window is 2^LEN_W-1 samples
- clk  in  1  sole clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- din  in  DATA_W  signed sample from the delay line output
- trig  in  1  start pulse, sampled on each posedge
- delay  in  DLY_W  cycles from trigger to first summed sample; latched at accepted trig
- len  in  LEN_W  samples to sum; latched at accepted trig
- sum_out  out  DATA_W+LEN_W  signed window sum; held until the next valid
- valid  out  1  one-cycle strobe; sum_out is new on this cycle
- busy  out  1  high whenever state is not IDLE
- overrun  out  1  sticky; a trig arrived while busy and was dropped

## Operation
- Reset applied at any time, including mid-window: state IDLE, accumulator 0, sum_out 0, valid 0, overrun 0; the in-flight window is discarded with no valid.
- States: IDLE, WAIT, ACC, DONE.
- IDLE + trig at edge T0: latch delay d and len n, clear accumulator; go to WAIT if d>0, else ACC if n>0, else DONE.
- WAIT: counts d edges (T0+1 .. T0+d); on the d-th edge go to ACC, or to DONE if n=0.
- ACC: at each edge T0+d+1 .. T0+d+n, acc <= acc + din (sign-extended to DATA_W+LEN_W); after the n-th add go to DONE.
- DONE: at next edge sum_out <= acc, valid <= 1, state IDLE.
- Arithmetic: no saturation needed; DATA_W+LEN_W bits hold n·(-2^(DATA_W-1)) exactly.
- n=0: valid still asserts, sum_out = 0.
- trig in WAIT/ACC/DONE: dropped; overrun set (sticky until rst).
- trig at the DONE->IDLE edge is treated as trig in DONE.

## Timing
- valid high for exactly one cycle following edge T0+d+n+1 (d=n=0: following edge T0+1).
- Samples summed: din values present at edges T0+d+1 through T0+d+n.
- busy high from the cycle after T0 through the cycle that valid is asserted; low in that cycle's successor.
- Minimum trigger spacing without overrun: d+n+2 cycles.
- delay/len changes while busy have no effect on the current window.

## Configuration
- WINDOW_INTEG_RETRIG_EN defined: trig in WAIT or ACC aborts the window (no valid), relatches delay/len, clears acc and restarts as if from IDLE. trig in DONE publishes the completing result normally and starts the new window on the same edge. overrun is tied 0.
- Undefined: behaviour as in Operation (drop and flag).

## Structure
- Shared package window_integ_pkg: state enum (IDLE, WAIT, ACC, DONE), DATA_W/DLY_W/LEN_W defaults, derived SUM_W = DATA_W+LEN_W.
- One sub-module, window_counter: loadable down-counter with terminal-count flag, reused for both the WAIT and ACC phases.

## Test plan
- Reset, then idle 10 cycles -> sum_out 0, valid 0, busy 0, overrun 0.
- d=3, n=4, din ramp 1,2,3,... starting at edge T0 value 0 -> sum_out = 4+5+6+7 = 22, valid exactly at T0+8.
- d=0, n=63, din constant -4096 -> sum_out = -258048, no wrap.
- d=0, n=0 -> valid at T0+1, sum_out 0.
- Second trig 2 cycles into a d=5, n=5 window -> macro off: result unaffected, overrun 1. Macro on: no valid for the first window; valid at second trig time +11.
- rst asserted mid-ACC, then a new trig -> no stale valid; new window sums correctly from 0.
